// File: rtl/telemetry_tx.sv
// Telemetry UART transmitter: snapshots battery/current/torque readings on vld_TX and sends a
// 9-byte framed packet (AA 55, three 12-bit readings, inverted checksum) as 8N1.
module telemetry_tx #(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vld_TX,
  input  logic [11:0] BATT_TX,
  input  logic [11:0] TORQUE_TX,
  input  logic [11:0] CURR_TX,
  output logic        TX,
  output logic        busy,
  output logic        pkt_done
);

  localparam int unsigned CntW = $clog2(BAUD_DIV);
  localparam logic [CntW-1:0] BaudLast = CntW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] baud_q;
  logic [2:0]      bit_q;
  logic [3:0]      byte_idx_q;
  logic [8:0]      shift_q;
  logic [11:0]     batt_q, curr_q, torque_q;
  logic            tx_q, busy_q, done_q;

  logic            baud_end, accept;
  logic [3:0]      next_idx;
  logic [7:0]      sum, next_byte;

  assign baud_end = (baud_q == BaudLast);
  assign accept   = vld_TX && !busy_q;
  assign next_idx = byte_idx_q + 4'd1;

  assign sum = {4'h0, batt_q[11:8]} + batt_q[7:0] + {4'h0, curr_q[11:8]} + curr_q[7:0] +
               {4'h0, torque_q[11:8]} + torque_q[7:0];

  // Byte that follows the current one; only consulted at the end of a stop bit.
  always_comb begin
    next_byte = 8'hAA;
    case (next_idx)
      4'd1:    next_byte = 8'h55;
      4'd2:    next_byte = {4'h0, batt_q[11:8]};
      4'd3:    next_byte = batt_q[7:0];
      4'd4:    next_byte = {4'h0, curr_q[11:8]};
      4'd5:    next_byte = curr_q[7:0];
      4'd6:    next_byte = {4'h0, torque_q[11:8]};
      4'd7:    next_byte = torque_q[7:0];
      4'd8:    next_byte = ~sum;
      default: next_byte = 8'hAA;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      baud_q     <= '0;
      bit_q      <= '0;
      byte_idx_q <= '0;
      shift_q    <= '1;
      batt_q     <= '0;
      curr_q     <= '0;
      torque_q   <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle, StDone: begin
          if (accept) begin
            batt_q     <= BATT_TX;
            curr_q     <= CURR_TX;
            torque_q   <= TORQUE_TX;
            shift_q    <= {1'b1, 8'hAA};
            tx_q       <= 1'b0;
            busy_q     <= 1'b1;
            baud_q     <= '0;
            bit_q      <= '0;
            byte_idx_q <= '0;
            state_q    <= StStart;
          end else begin
            state_q <= StIdle;
          end
        end
        StStart: begin
          if (baud_end) begin
            baud_q  <= '0;
            tx_q    <= shift_q[0];
            shift_q <= {1'b0, shift_q[8:1]};
            bit_q   <= '0;
            state_q <= StData;
          end else begin
            baud_q <= baud_q + CntW'(1);
          end
        end
        StData: begin
          if (baud_end) begin
            baud_q  <= '0;
            // After the eighth data bit the stop bit (the loaded 1) sits at shift_q[0].
            tx_q    <= shift_q[0];
            shift_q <= {1'b0, shift_q[8:1]};
            if (bit_q == 3'd7) begin
              state_q <= StStop;
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q + CntW'(1);
          end
        end
        StStop: begin
          if (baud_end) begin
            baud_q <= '0;
            if (byte_idx_q == 4'd8) begin
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              byte_idx_q <= next_idx;
              shift_q    <= {1'b1, next_byte};
              tx_q       <= 1'b0;
              state_q    <= StStart;
            end
          end else begin
            baud_q <= baud_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign TX       = tx_q;
  assign busy     = busy_q;
  assign pkt_done = done_q;

endmodule

// File: tb/tb_telemetry_tx.sv
// Bench for telemetry_tx: a reference model queues expected bytes, a UART decoder pops and checks.
module tb_telemetry_tx;

  localparam int unsigned Baud      = 16;
  localparam int unsigned PktCycles = 90 * Baud;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld_TX;
  logic [11:0] batt, torque, curr;
  logic        TX, busy, pkt_done;

  int checks = 0;
  int passes = 0;
  int epoch = 0;
  int pkts_expected = 0;
  int done_cnt = 0;
  logic [7:0] sb[$];

  telemetry_tx #(.BAUD_DIV(Baud)) dut (
    .clk      (clk),
    .rst      (rst),
    .vld_TX   (vld_TX),
    .BATT_TX  (batt),
    .TORQUE_TX(torque),
    .CURR_TX  (curr),
    .TX       (TX),
    .busy     (busy),
    .pkt_done (pkt_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (pkt_done === 1'b1) done_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: packet bytes from the readings with plain integer arithmetic.
  task automatic push_expected(input logic [11:0] b, input logic [11:0] c, input logic [11:0] t);
    int vals[3];
    int bytes[9];
    int s;
    vals = '{int'(b), int'(c), int'(t)};
    bytes[0] = 170;
    bytes[1] = 85;
    for (int i = 0; i < 3; i++) begin
      bytes[2 + 2 * i] = vals[i] / 256;
      bytes[3 + 2 * i] = vals[i] % 256;
    end
    s = 0;
    for (int i = 2; i < 8; i++) s += bytes[i];
    bytes[8] = 255 - (s % 256);
    for (int i = 0; i < 9; i++) sb.push_back(8'(bytes[i]));
    pkts_expected++;
  endtask

  // Called at a negedge; the request is sampled on the next posedge.
  task automatic start_pkt(input logic [11:0] b, input logic [11:0] c, input logic [11:0] t);
    push_expected(b, c, t);
    batt   = b;
    curr   = c;
    torque = t;
    vld_TX = 1'b1;
    @(posedge clk);
    #1;
    chk("start_bit_latency", {30'd0, TX, busy}, 32'b01);
    vld_TX = 1'b0;
  endtask

  // Returns at the negedge of the DONE cycle; optionally pokes a request mid-packet.
  task automatic wait_done(input int poke);
    int   n;
    logic bad;
    n   = 0;
    bad = 1'b0;
    while (n < 3000) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (pkt_done) bad = 1'b1;
      if (n == poke) begin
        batt   = 12'h000;
        curr   = 12'h000;
        torque = 12'h000;
        vld_TX = 1'b1;
      end else begin
        vld_TX = 1'b0;
      end
    end
    chk("busy_cycles", n, PktCycles);
    chk("pkt_done_at_end", {29'd0, pkt_done, TX, bad}, 32'b110);
  endtask

  // UART decoder: samples mid-bit on negedges, compares each byte with the scoreboard head.
  initial begin : monitor
    int         ep;
    logic       st, sp;
    logic [7:0] d;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && TX === 1'b0) begin
        ep = epoch;
        repeat (Baud / 2) @(negedge clk);
        st = TX;
        for (int i = 0; i < 8; i++) begin
          repeat (Baud) @(negedge clk);
          d[i] = TX;
        end
        repeat (Baud) @(negedge clk);
        sp = TX;
        if (ep == epoch) begin
          if (sb.size() == 0) begin
            checks++;
            $display("FAIL rx_unexpected: got 0x%0h, expected no byte at %0t", d, $time);
          end else begin
            chk("rx_byte", {22'd0, st, sp, d}, {22'd0, 1'b0, 1'b1, sb.pop_front()});
          end
        end
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic bad;
    int   dc;
    rst    = 1'b1;
    vld_TX = 1'b0;
    batt   = '0;
    curr   = '0;
    torque = '0;
    repeat (5) @(negedge clk);
    chk("reset_state", {29'd0, TX, busy, pkt_done}, 32'b100);
    rst = 1'b0;

    bad = 1'b0;
    repeat (2000) begin
      @(negedge clk);
      if ({TX, busy, pkt_done} !== 3'b100) bad = 1'b1;
    end
    chk("idle_2000", {31'd0, bad}, 32'd0);

    // Basic packet
    start_pkt(12'hABC, 12'h123, 12'h700);
    wait_done(0);
    @(negedge clk);
    chk("idle_after_done", {29'd0, TX, busy, pkt_done}, 32'b100);
    chk("basic_drained", sb.size(), 0);

    // All-ones readings exercise checksum wrap
    start_pkt(12'hFFF, 12'hFFF, 12'hFFF);
    wait_done(0);
    @(negedge clk);
    chk("max_drained", sb.size(), 0);

    // Request while busy is ignored; inputs change after latching
    dc = done_cnt;
    start_pkt(12'h5A3, 12'h0C6, 12'h9E1);
    wait_done(500);
    @(negedge clk);
    chk("ignored_drained", sb.size(), 0);
    chk("ignored_single_done", done_cnt, dc + 1);
    chk("ignored_stays_idle", {31'd0, busy}, 32'd0);

    // Back-to-back: next request lands in the DONE cycle
    start_pkt(12'h111, 12'h222, 12'h333);
    wait_done(0);
    start_pkt(12'hE4D, 12'h08F, 12'h6B2);
    wait_done(0);
    @(negedge clk);
    chk("b2b_drained", sb.size(), 0);

    // Randomised readings with random gaps (including none)
    for (int k = 0; k < 4; k++) begin
      start_pkt(12'($urandom), 12'($urandom), 12'($urandom));
      wait_done(0);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 20)) @(negedge clk);
    end
    @(negedge clk);
    chk("rand_drained", sb.size(), 0);

    // Reset during byte 4
    start_pkt(12'h246, 12'h8AC, 12'hDEF);
    repeat (700) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_reset", {30'd0, TX, busy}, 32'b10);
    sb.delete();
    epoch++;
    pkts_expected--;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    chk("post_reset_idle", {29'd0, TX, busy, pkt_done}, 32'b100);
    start_pkt(12'h001, 12'h002, 12'h003);
    wait_done(0);
    @(negedge clk);
    chk("post_reset_drained", sb.size(), 0);

    repeat (20) @(negedge clk);
    chk("pkt_done_count", done_cnt, pkts_expected);
    chk("sb_final", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
